// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
//   Shared types, constants and helpers for the BCD timekeeper.
//   - bcd_t           : one BCD digit (0..9 in 4 bits)
//   - time_t          : packed hh:mm:ss, six BCD digits, hour tens in [23:20]
//   - SEC_MAX/MIN_MAX : two-digit BCD wrap points for seconds and minutes
//   - HOUR24_MAX/HOUR12_MAX : last hour value in each display mode
//   - bcd2_inc        : increment of a two-digit BCD value (no wrap handling)
//   - bcd_time_valid  : checks that a time_t is a legal display value for
//                       the given hour mode (24 or 12)
// ----------------------------------------------------------------------------
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hour_tens;
        bcd_t hour_units;
        bcd_t min_tens;
        bcd_t min_units;
        bcd_t sec_tens;
        bcd_t sec_units;
    } time_t;

    localparam logic [7:0] SEC_MAX    = 8'h59;
    localparam logic [7:0] MIN_MAX    = 8'h59;
    localparam logic [7:0] HOUR24_MAX = 8'h23;
    localparam logic [7:0] HOUR12_MAX = 8'h12;

    // Two-digit BCD +1. The caller handles the upper wrap point, so 99 is
    // never presented here.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Once every nibble is known to be <= 9, an 8-bit compare of two BCD
    // digits orders the same way as the decimal value, so hour limits can be
    // checked directly against BCD constants.
    function automatic logic bcd_time_valid(input time_t t, input int hour_mode);
        logic [7:0] hh;
        logic       ok;
        hh = {t.hour_tens, t.hour_units};
        ok = (t.hour_tens <= 4'd9) && (t.hour_units <= 4'd9) &&
             (t.min_tens  <= 4'd9) && (t.min_units  <= 4'd9) &&
             (t.sec_tens  <= 4'd9) && (t.sec_units  <= 4'd9);
        ok = ok && (t.min_tens <= 4'd5) && (t.sec_tens <= 4'd5);
        if (hour_mode == 12) begin
            ok = ok && (hh >= 8'h01) && (hh <= HOUR12_MAX);
        end else begin
            ok = ok && (hh <= HOUR24_MAX);
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// ----------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD counter that counts MIN..MAX and wraps back to MIN.
//   Reset value is MIN. Parallel load has priority over increment; the load
//   value is assumed to be pre-validated by the parent.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     inc_i        : count enable for this cycle
//     load_i       : load load_val_i on this edge (overrides inc_i)
//     load_val_i   : two-digit BCD value to load
//     val_o        : current registered value
//     next_o       : value that will be registered on the next edge
//     carry_o      : combinational, high when inc_i wraps MAX -> MIN, so the
//                    next stage can advance in the same cycle
// ----------------------------------------------------------------------------
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59,
    parameter logic [7:0] MIN = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] val_o,
    output logic [7:0] next_o,
    output logic       carry_o
);

    logic [7:0] val_q;
    logic [7:0] val_d;

    always_comb begin
        val_d   = val_q;
        carry_o = 1'b0;
        if (load_i) begin
            val_d = load_val_i;
        end else if (inc_i) begin
            if (val_q == MAX) begin
                val_d   = MIN;
                carry_o = 1'b1;
            end else begin
                val_d = bcd2_inc(val_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= MIN;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o  = val_q;
    assign next_o = val_d;

endmodule

// File: rtl/bcd_timekeeper.sv
// ----------------------------------------------------------------------------
// bcd_timekeeper
//   Single-clock hh:mm:ss BCD time-of-day counter advanced by a tick enable
//   through a prescaler, with 12/24 h display, run/hold and a validated
//   parallel load. Carry pulses are registered and line up with the digit
//   update that caused them.
//
//   Parameters:
//     HOUR_MODE     : 24 -> hours 00..23, 12 -> hours 01..12 plus pm flag
//     TICKS_PER_SEC : tick pulses per one-second advance, 1..1023
//
//   Optional feature macro: BCD_TIMEKEEPER_ALARM_EN
//     defined   : alarm_set latches a validated alarm time and arms it;
//                 alarm pulses when a tick advance lands on that time
//     undefined : alarm ports stay, alarm is 0, alarm inputs are ignored
//
//   Ports:
//     clk, rst         : clock, synchronous active-high reset
//     tick             : one-cycle timebase enable
//     run              : 1 = count, 0 = hold (prescaler frozen)
//     load, load_digit, load_pm : one-cycle validated time load
//     digit, pm        : packed BCD hh:mm:ss display bus and pm flag
//     min_tick, hour_tick, day_tick : one-cycle carry pulses
//     load_err         : one-cycle pulse when a load/alarm_set is rejected
//     alarm_set, alarm_digit, alarm_pm, alarm : alarm interface
//
//   Valid/ready: there is no back-pressure; load, alarm_set and tick are
//   single-cycle requests that are always accepted in the cycle they are
//   high, with priority rst > load > tick.
// ----------------------------------------------------------------------------
module bcd_timekeeper
    import clock_pkg::*;
#(
    parameter int HOUR_MODE     = 24,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        run,
    input  logic        load,
    input  logic [23:0] load_digit,
    input  logic        load_pm,
    output logic [23:0] digit,
    output logic        pm,
    output logic        min_tick,
    output logic        hour_tick,
    output logic        day_tick,
    output logic        load_err,
    input  logic        alarm_set,
    input  logic [23:0] alarm_digit,
    input  logic        alarm_pm,
    output logic        alarm
);

    if (!(HOUR_MODE == 24 || HOUR_MODE == 12)) begin : g_bad_hour_mode
        $error("bcd_timekeeper: HOUR_MODE must be 12 or 24");
    end
    if (TICKS_PER_SEC < 1 || TICKS_PER_SEC > 1023) begin : g_bad_tps
        $error("bcd_timekeeper: TICKS_PER_SEC must be 1..1023");
    end

    localparam int         PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0] HOUR_RESET = (HOUR_MODE == 12) ? 8'h12 : 8'h00;
    localparam logic [7:0] HOUR_LAST  = (HOUR_MODE == 12) ? HOUR12_MAX : HOUR24_MAX;
    localparam logic [7:0] HOUR_FIRST = (HOUR_MODE == 12) ? 8'h01 : 8'h00;

    // ------------------------------------------------------------------
    // Load decode
    // ------------------------------------------------------------------
    time_t load_t;
    logic  load_ok;
    logic  load_bad;
    logic  alarm_bad;

    assign load_t   = time_t'(load_digit);
    assign load_ok  = load & bcd_time_valid(load_t, HOUR_MODE);
    assign load_bad = load & ~load_ok;

    // ------------------------------------------------------------------
    // Prescaler. Any load (valid or not) takes the cycle, so a tick that
    // arrives with it is dropped rather than counted.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_en;
    logic          adv;

    assign tick_en = run & tick & ~load;
    assign adv     = tick_en & (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        if (load_ok) begin
            presc_d = '0;
        end else if (tick_en) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Seconds and minutes: carries ripple combinationally so a full
    // rollover completes on one edge.
    // ------------------------------------------------------------------
    logic [7:0] sec_val;
    logic [7:0] sec_next;
    logic       sec_carry;
    logic [7:0] min_val;
    logic [7:0] min_next;
    logic       min_carry;

    bcd_mod_counter #(
        .MAX (SEC_MAX),
        .MIN (8'h00)
    ) u_sec (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (adv),
        .load_i     (load_ok),
        .load_val_i ({load_t.sec_tens, load_t.sec_units}),
        .val_o      (sec_val),
        .next_o     (sec_next),
        .carry_o    (sec_carry)
    );

    bcd_mod_counter #(
        .MAX (MIN_MAX),
        .MIN (8'h00)
    ) u_min (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (sec_carry),
        .load_i     (load_ok),
        .load_val_i ({load_t.min_tens, load_t.min_units}),
        .val_o      (min_val),
        .next_o     (min_next),
        .carry_o    (min_carry)
    );

    // ------------------------------------------------------------------
    // Hours and pm. In 12 h mode the displayed sequence is
    // 12,01,..,11,12 with pm toggling on 11->12; the day ends on the
    // 11 pm -> 12 am step. In 24 h mode the day ends on 23->00.
    // ------------------------------------------------------------------
    logic [7:0] hour_q;
    logic [7:0] hour_d;
    logic       pm_q;
    logic       pm_d;
    logic       day_wrap;

    always_comb begin
        hour_d   = hour_q;
        pm_d     = pm_q;
        day_wrap = 1'b0;
        if (load_ok) begin
            hour_d = {load_t.hour_tens, load_t.hour_units};
            pm_d   = (HOUR_MODE == 12) ? load_pm : 1'b0;
        end else if (min_carry) begin
            if (hour_q == HOUR_LAST) begin
                hour_d   = HOUR_FIRST;
                day_wrap = (HOUR_MODE == 24);
            end else begin
                hour_d = bcd2_inc(hour_q);
                if (HOUR_MODE == 12 && hour_q == 8'h11) begin
                    pm_d     = ~pm_q;
                    day_wrap = pm_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State and pulse registers
    // ------------------------------------------------------------------
    logic min_tick_q;
    logic hour_tick_q;
    logic day_tick_q;
    logic load_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_q      <= HOUR_RESET;
            pm_q        <= 1'b0;
            presc_q     <= '0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            hour_q      <= hour_d;
            pm_q        <= pm_d;
            presc_q     <= presc_d;
            min_tick_q  <= sec_carry;
            hour_tick_q <= min_carry;
            day_tick_q  <= day_wrap;
            load_err_q  <= load_bad | alarm_bad;
        end
    end

    assign digit     = {hour_q, min_val, sec_val};
    assign pm        = pm_q;
    assign min_tick  = min_tick_q;
    assign hour_tick = hour_tick_q;
    assign day_tick  = day_tick_q;
    assign load_err  = load_err_q;

    // ------------------------------------------------------------------
    // Alarm
    // ------------------------------------------------------------------
`ifdef BCD_TIMEKEEPER_ALARM_EN
    time_t alarm_time_q;
    logic  alarm_pm_q;
    logic  alarm_armed_q;
    logic  alarm_q;
    logic  alarm_ok;
    time_t next_time;

    assign alarm_ok  = alarm_set & bcd_time_valid(time_t'(alarm_digit), HOUR_MODE);
    assign alarm_bad = alarm_set & ~alarm_ok;
    assign next_time = time_t'({hour_d, min_next, sec_next});

    // The match is taken against the value about to be registered, and only
    // on an advance, so a load that lands on the alarm time stays silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_time_q  <= time_t'({HOUR_RESET, 16'h0000});
            alarm_pm_q    <= 1'b0;
            alarm_armed_q <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            alarm_q <= alarm_armed_q & adv & (next_time == alarm_time_q) &
                       (pm_d == alarm_pm_q);
            if (alarm_ok) begin
                alarm_time_q  <= time_t'(alarm_digit);
                alarm_pm_q    <= (HOUR_MODE == 12) ? alarm_pm : 1'b0;
                alarm_armed_q <= 1'b1;
            end
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_alarm;

    assign alarm_bad    = 1'b0;
    assign alarm        = 1'b0;
    assign unused_alarm = ^{alarm_set, alarm_digit, alarm_pm, sec_next, min_next};
`endif

endmodule
